// File: rtl/mips_mem_defs.sv
// rtl/mips_mem_defs.sv - shared MEM-stage control field indices and access size codes
package mips_mem_defs;

  localparam int MEM_READ     = 5;
  localparam int MEM_WRITE    = 4;
  localparam int MEM_UNSIGNED = 3;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_RSVD = 2'b10,
    SZ_WORD = 2'b11
  } mem_size_e;

  // The unused size code 10 behaves like a word access.
  function automatic logic is_aligned(input mem_size_e size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~lane[0];
      default: is_aligned = (lane == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/data_memory.sv
// rtl/data_memory.sv - word-organised data RAM, byte-enable sync write, pipeline and debug async reads
module data_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 7
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_write_enable,
  input  logic [NB_DATA/8-1:0] i_byte_enable,
  input  logic [NB_ADDR-1:0]   i_write_addr,
  input  logic [NB_DATA-1:0]   i_write_data,
  input  logic [NB_ADDR-1:0]   i_read_addr,
  output logic [NB_DATA-1:0]   o_read_data,
  input  logic [NB_ADDR-1:0]   i_debug_addr,
  output logic [NB_DATA-1:0]   o_debug_data
);

  localparam int DEPTH = 2 ** NB_ADDR;
  localparam int NB_BE = NB_DATA / 8;

  logic [NB_DATA-1:0] mem [DEPTH];

  // Contents survive reset; reset only blocks a write landing on the same edge.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
    end else if (i_write_enable) begin
      for (int b = 0; b < NB_BE; b++) begin
        if (i_byte_enable[b]) begin
          mem[i_write_addr][b*8 +: 8] <= i_write_data[b*8 +: 8];
        end
      end
    end
  end

  assign o_read_data  = mem[i_read_addr];
  assign o_debug_data = mem[i_debug_addr];

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MIPS MEM stage: lane steering, alignment check, load extension, MEM/WB latch
module mem_access_stage
  import mips_mem_defs::*;
#(
  parameter int NB_DATA    = 32,
  parameter int NB_REG     = 5,
  parameter int NB_M_CTRL  = 6,
  parameter int NB_WB_CTRL = 3,
  parameter int NB_ADDR    = 7
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic [NB_DATA-1:0]    i_result_alu,
  input  logic [NB_DATA-1:0]    i_data_write_mem,
  input  logic [NB_REG-1:0]     i_write_register,
  input  logic [NB_M_CTRL-1:0]  i_M_control,
  input  logic [NB_WB_CTRL-1:0] i_WB_control,
  input  logic [NB_ADDR-1:0]    i_debug_addr,
  output logic [NB_DATA-1:0]    o_debug_data,
  output logic [NB_DATA-1:0]    o_read_data,
  output logic [NB_DATA-1:0]    o_result_alu,
  output logic [NB_REG-1:0]     o_write_register,
  output logic [NB_WB_CTRL-1:0] o_WB_control,
  output logic                  o_misaligned
);

  localparam int NB_BE = NB_DATA / 8;

  logic [NB_ADDR-1:0] word_addr;
  logic [1:0]         lane;
  mem_size_e          size;
  logic               mem_read;
  logic               mem_write;
  logic               is_unsigned;
  logic               aligned;
  logic               do_store;
  logic [NB_BE-1:0]   byte_en;
  logic [NB_DATA-1:0] store_data;
  logic [NB_DATA-1:0] mem_word;
  logic [7:0]         load_byte;
  logic [15:0]        load_half;
  logic [NB_DATA-1:0] load_ext;
  logic [NB_DATA-1:0] read_data_next;
  logic               misaligned_next;
  logic               unused_bits;

  assign word_addr   = i_result_alu[NB_ADDR+1:2];
  assign lane        = i_result_alu[1:0];
  assign size        = mem_size_e'(i_M_control[1:0]);
  assign mem_read    = i_M_control[MEM_READ];
  assign mem_write   = i_M_control[MEM_WRITE];
  assign is_unsigned = i_M_control[MEM_UNSIGNED];
  assign unused_bits = ^{i_result_alu[NB_DATA-1:NB_ADDR+2], i_M_control[2]};

  assign aligned  = is_aligned(size, lane);
  assign do_store = i_enable & mem_write & aligned;

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    byte_en    = '1;
    store_data = i_data_write_mem;
    case (size)
      SZ_BYTE: begin
        byte_en    = NB_BE'(1) << lane;
        store_data = {NB_BE{i_data_write_mem[7:0]}};
      end
      SZ_HALF: begin
        byte_en    = NB_BE'(3) << {lane[1], 1'b0};
        store_data = {(NB_BE/2){i_data_write_mem[15:0]}};
      end
      default: begin
        byte_en    = '1;
        store_data = i_data_write_mem;
      end
    endcase
  end

  data_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_data_memory (
    .i_clock        (i_clock),
    .i_reset_n      (i_reset_n),
    .i_write_enable (do_store),
    .i_byte_enable  (byte_en),
    .i_write_addr   (word_addr),
    .i_write_data   (store_data),
    .i_read_addr    (word_addr),
    .o_read_data    (mem_word),
    .i_debug_addr   (i_debug_addr),
    .o_debug_data   (o_debug_data)
  );

  assign load_byte = mem_word[{lane, 3'b000} +: 8];
  assign load_half = mem_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = mem_word;
    case (size)
      SZ_BYTE: load_ext = is_unsigned ? {{(NB_DATA-8){1'b0}}, load_byte}
                                      : {{(NB_DATA-8){load_byte[7]}}, load_byte};
      SZ_HALF: load_ext = is_unsigned ? {{(NB_DATA-16){1'b0}}, load_half}
                                      : {{(NB_DATA-16){load_half[15]}}, load_half};
      default: load_ext = mem_word;
    endcase
  end

  // A combined read+write slot is treated as a store and returns no load data.
  assign read_data_next  = (mem_read && !mem_write && aligned) ? load_ext : '0;
  assign misaligned_next = (mem_read | mem_write) & ~aligned;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_read_data      <= '0;
      o_result_alu     <= '0;
      o_write_register <= '0;
      o_WB_control     <= '0;
      o_misaligned     <= 1'b0;
    end else if (i_enable) begin
      o_read_data      <= read_data_next;
      o_result_alu     <= i_result_alu;
      o_write_register <= i_write_register;
      o_WB_control     <= i_WB_control;
      o_misaligned     <= misaligned_next;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized self-checking bench for mem_access_stage with a byte-array model
module tb_mem_access_stage;

  localparam logic [5:0] MC_LW  = 6'b100011;
  localparam logic [5:0] MC_SW  = 6'b010011;
  localparam logic [5:0] MC_LB  = 6'b100000;
  localparam logic [5:0] MC_LBU = 6'b101000;
  localparam logic [5:0] MC_SB  = 6'b010000;
  localparam logic [5:0] MC_LH  = 6'b100001;
  localparam logic [5:0] MC_SH  = 6'b010001;

  logic        i_clock = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_enable = 1'b0;
  logic [31:0] i_result_alu = '0;
  logic [31:0] i_data_write_mem = '0;
  logic [4:0]  i_write_register = '0;
  logic [5:0]  i_M_control = '0;
  logic [2:0]  i_WB_control = '0;
  logic [6:0]  i_debug_addr = '0;
  logic [31:0] o_debug_data;
  logic [31:0] o_read_data;
  logic [31:0] o_result_alu;
  logic [4:0]  o_write_register;
  logic [2:0]  o_WB_control;
  logic        o_misaligned;

  int total = 0;
  int bad = 0;

  logic [7:0]  bytes [512];
  logic [31:0] e_rdata = '0;
  logic [31:0] e_alu = '0;
  logic [4:0]  e_rd = '0;
  logic [2:0]  e_wb = '0;
  logic        e_mis = 1'b0;

  always #5 i_clock = ~i_clock;

  mem_access_stage dut (
    .i_clock          (i_clock),
    .i_reset_n        (i_reset_n),
    .i_enable         (i_enable),
    .i_result_alu     (i_result_alu),
    .i_data_write_mem (i_data_write_mem),
    .i_write_register (i_write_register),
    .i_M_control      (i_M_control),
    .i_WB_control     (i_WB_control),
    .i_debug_addr     (i_debug_addr),
    .o_debug_data     (o_debug_data),
    .o_read_data      (o_read_data),
    .o_result_alu     (o_result_alu),
    .o_write_register (o_write_register),
    .o_WB_control     (o_WB_control),
    .o_misaligned     (o_misaligned)
  );

  function automatic logic [31:0] model_word(input int idx);
    return {bytes[idx*4+3], bytes[idx*4+2], bytes[idx*4+1], bytes[idx*4]};
  endfunction

  task automatic check_outputs(input string tag);
    total++;
    if (o_read_data !== e_rdata) begin
      bad++; $display("FAIL %s read_data got=%h exp=%h", tag, o_read_data, e_rdata);
    end
    total++;
    if (o_result_alu !== e_alu) begin
      bad++; $display("FAIL %s result_alu got=%h exp=%h", tag, o_result_alu, e_alu);
    end
    total++;
    if (o_write_register !== e_rd) begin
      bad++; $display("FAIL %s write_register got=%0d exp=%0d", tag, o_write_register, e_rd);
    end
    total++;
    if (o_WB_control !== e_wb) begin
      bad++; $display("FAIL %s WB_control got=%b exp=%b", tag, o_WB_control, e_wb);
    end
    total++;
    if (o_misaligned !== e_mis) begin
      bad++; $display("FAIL %s misaligned got=%b exp=%b", tag, o_misaligned, e_mis);
    end
  endtask

  // One pipeline slot: drive at negedge, check debug before the edge, check MEM/WB after it.
  task automatic do_op(input string tag, input logic en, input logic [5:0] mc,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] rd, input logic [2:0] wb);
    int base, nbytes, dbg;
    logic rd_f, wr_f, mis;
    logic [63:0] v;
    i_enable = en; i_M_control = mc; i_result_alu = addr;
    i_data_write_mem = data; i_write_register = rd; i_WB_control = wb;
    i_debug_addr = addr[8:2];
    #1;
    total++;
    if (o_debug_data !== model_word(int'(addr[8:2]))) begin
      bad++; $display("FAIL %s debug_pre got=%h exp=%h", tag, o_debug_data, model_word(int'(addr[8:2])));
    end
    rd_f = mc[5]; wr_f = mc[4];
    nbytes = (mc[1:0] == 2'b00) ? 1 : (mc[1:0] == 2'b01) ? 2 : 4;
    base = int'(addr % 512);
    mis = (rd_f || wr_f) && ((base % nbytes) != 0);
    if (en) begin
      v = '0;
      if (rd_f && !wr_f && !mis) begin
        for (int i = 0; i < nbytes; i++) v = v | (64'(bytes[base+i]) << (8*i));
        if (!mc[3] && v[8*nbytes-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*nbytes));
      end
      e_rdata = v[31:0]; e_alu = addr; e_rd = rd; e_wb = wb; e_mis = mis;
      if (wr_f && !mis)
        for (int i = 0; i < nbytes; i++) bytes[base+i] = data[8*i +: 8];
    end
    @(posedge i_clock);
    @(negedge i_clock);
    check_outputs(tag);
    dbg = $urandom_range(0, 127);
    i_debug_addr = 7'(dbg);
    #1;
    total++;
    if (o_debug_data !== model_word(dbg)) begin
      bad++; $display("FAIL %s debug_post[%0d] got=%h exp=%h", tag, dbg, o_debug_data, model_word(dbg));
    end
  endtask

  task automatic test_reset;
    i_reset_n = 1'b0;
    #3;
    e_rdata = '0; e_alu = '0; e_rd = '0; e_wb = '0; e_mis = 1'b0;
    check_outputs("reset");
    @(negedge i_clock);
    i_reset_n = 1'b1;
    for (int w = 0; w < 128; w++) begin
      i_enable = 1'b1; i_M_control = MC_SW; i_result_alu = 32'(w * 4); i_data_write_mem = '0;
      @(posedge i_clock);
      @(negedge i_clock);
    end
    for (int i = 0; i < 512; i++) bytes[i] = 8'h00;
    e_rdata = '0; e_alu = 32'(127 * 4); e_rd = '0; e_wb = '0; e_mis = 1'b0;
  endtask

  task automatic test_word;
    do_op("sw_word", 1, MC_SW, 32'h10, 32'hDEADBEEF, 5'd1, 3'b001);
    do_op("lw_word", 1, MC_LW, 32'h10, 32'h0, 5'd2, 3'b011);
    i_debug_addr = 7'd4;
    #1;
    total++;
    if (o_read_data !== 32'hDEADBEEF || o_debug_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL word_const rdata=%h dbg=%h exp=deadbeef", o_read_data, o_debug_data);
    end
  endtask

  task automatic test_byte;
    do_op("clr_word", 1, MC_SW, 32'h10, 32'h0, 5'd0, 3'b000);
    do_op("sb_lane3", 1, MC_SB, 32'h13, 32'h80, 5'd3, 3'b000);
    i_debug_addr = 7'd4;
    #1;
    total++;
    if (o_debug_data !== 32'h80000000) begin
      bad++; $display("FAIL sb_const got=%h exp=80000000", o_debug_data);
    end
    do_op("lb_lane3", 1, MC_LB, 32'h13, 32'h0, 5'd4, 3'b001);
    total++;
    if (o_read_data !== 32'hFFFFFF80) begin
      bad++; $display("FAIL lb_const got=%h exp=ffffff80", o_read_data);
    end
    do_op("lbu_lane3", 1, MC_LBU, 32'h13, 32'h0, 5'd5, 3'b001);
    total++;
    if (o_read_data !== 32'h00000080) begin
      bad++; $display("FAIL lbu_const got=%h exp=00000080", o_read_data);
    end
  endtask

  task automatic test_half;
    do_op("sw_pre", 1, MC_SW, 32'h20, 32'hAAAABBBB, 5'd6, 3'b000);
    do_op("sh_upper", 1, MC_SH, 32'h22, 32'h00001234, 5'd7, 3'b000);
    do_op("lh_misal", 1, MC_LH, 32'h21, 32'h0, 5'd8, 3'b110);
    i_debug_addr = 7'd8;
    #1;
    total++;
    if (o_misaligned !== 1'b1 || o_read_data !== 32'h0 || o_debug_data !== 32'h1234BBBB) begin
      bad++; $display("FAIL half_const mis=%b rdata=%h dbg=%h exp=1/0/1234bbbb", o_misaligned, o_read_data, o_debug_data);
    end
    do_op("sh_misal", 1, MC_SH, 32'h23, 32'h0000FFFF, 5'd9, 3'b010);
  endtask

  task automatic test_enable;
    do_op("lw_before", 1, MC_LW, 32'h20, 32'h0, 5'd10, 3'b111);
    do_op("sw_frozen", 0, MC_SW, 32'h0, 32'h55, 5'd11, 3'b001);
    do_op("lw_frozen", 0, MC_LW, 32'h0, 32'h0, 5'd12, 3'b001);
    do_op("lw_word0", 1, MC_LW, 32'h0, 32'h0, 5'd13, 3'b001);
  endtask

  task automatic test_reset_mid;
    do_op("lw_prereset", 1, MC_LW, 32'h10, 32'h0, 5'd14, 3'b101);
    i_enable = 1'b1; i_M_control = MC_SW; i_result_alu = 32'h10; i_data_write_mem = 32'h12345678;
    #2;
    i_reset_n = 1'b0;
    #1;
    e_rdata = '0; e_alu = '0; e_rd = '0; e_wb = '0; e_mis = 1'b0;
    check_outputs("reset_mid");
    @(posedge i_clock);
    @(negedge i_clock);
    i_reset_n = 1'b1;
    check_outputs("reset_hold");
    do_op("lw_postreset", 1, MC_LW, 32'h10, 32'h0, 5'd15, 3'b001);
  endtask

  task automatic test_alias;
    do_op("sw_alias", 1, MC_SW, 32'h200, 32'hCAFEF00D, 5'd31, 3'b101);
    total++;
    if (o_write_register !== 5'd31 || o_WB_control !== 3'b101) begin
      bad++; $display("FAIL alias_pass rd=%0d wb=%b exp=31/101", o_write_register, o_WB_control);
    end
    do_op("lw_alias", 1, MC_LW, 32'h0, 32'h0, 5'd1, 3'b000);
    total++;
    if (o_read_data !== 32'hCAFEF00D) begin
      bad++; $display("FAIL alias_const got=%h exp=cafef00d", o_read_data);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, d;
      a = {$urandom_range(0, 127), 2'b00};
      d = $urandom;
      do_op("b2b_store", 1, MC_SW, a, d, 5'(i), 3'b001);
      do_op("b2b_load", 1, ($urandom_range(0, 1) != 0) ? MC_LB : MC_LW, a + 32'($urandom_range(0, 3) & 0), 32'h0, 5'(i), 3'b010);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      logic [5:0]  mc;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'h0000_01FC | 32'($urandom_range(0, 3) & ($urandom_range(0, 1) != 0 ? 3 : 0));
      mc = 6'($urandom);
      do_op("random", ($urandom_range(0, 9) != 0), mc, a, $urandom, 5'($urandom), 3'($urandom));
    end
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_enable;
    test_reset_mid;
    test_alias;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
